// File: rtl/div_seq_if.sv
// div_seq_if: request/result bundle between the issue logic and the
// sequential divider.
//
// Handshake: the issuer raises start with rs1_reg/rs2_reg while busy is low.
// The divider accepts on that rising edge and holds busy high until its
// one-cycle done pulse ends. A start seen while busy is dropped, not queued.
// quo_rd, rem_rd and div_zero are valid during done and stay put until the
// next operation's done. div_zero drops when a new operation is accepted.
//
// Signals:
//   start    request a divide (issuer -> divider)
//   rs1_reg  dividend, N bits (issuer -> divider)
//   rs2_reg  divisor, N bits (issuer -> divider)
//   busy     divider is not idle
//   done     one-cycle result-valid pulse
//   quo_rd   quotient, N bits
//   rem_rd   remainder, N bits
//   div_zero result came from a zero divisor
interface div_seq_if #(
  parameter int N = 16
);
  logic         start;
  logic [N-1:0] rs1_reg;
  logic [N-1:0] rs2_reg;
  logic         busy;
  logic         done;
  logic [N-1:0] quo_rd;
  logic [N-1:0] rem_rd;
  logic         div_zero;

  modport master (
    output start, rs1_reg, rs2_reg,
    input  busy, done, quo_rd, rem_rd, div_zero
  );

  modport slave (
    input  start, rs1_reg, rs2_reg,
    output busy, done, quo_rd, rem_rd, div_zero
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: multi-cycle unsigned restoring divider. One N-bit subtractor is
// reused for N cycles, producing one quotient bit per cycle.
//
// A zero divisor skips the iteration. In that case the result is an
// all-ones quotient, the remainder is the dividend, and div_zero is set.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        div_seq_if slave: start/operands in, busy/done/results out
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
module div_seq #(
  parameter int N = 16
) (
  input  logic       clk,
  input  logic       rst,
  div_seq_if.slave   bus,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  dvd;      // dividend shifting out, quotient shifting in
  logic [N-1:0]  dvs;
  logic [N-1:0]  acc;      // partial remainder
  logic [CW-1:0] cnt;

  // The remainder path is N+1 bits wide, so acc[N-1] is not lost on the
  // shift. Without that bit, divisors >= 2^(N-1) would give wrong results.
  // The subtract is N+2 bits, so its top bit is a clean borrow flag.
  logic [N:0]    shifted;
  logic [N+1:0]  diff;
  logic          borrow;
  logic [N-1:0]  acc_nxt;
  logic [N-1:0]  dvd_nxt;

  always_comb begin
    shifted = {acc, dvd[N-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs};
    borrow  = diff[N+1];
    // On borrow, shifted < dvs < 2^N, so its low N bits hold it exactly.
    acc_nxt = borrow ? shifted[N-1:0] : diff[N-1:0];
    dvd_nxt = {dvd[N-2:0], ~borrow};
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dvd          <= '0;
      dvs          <= '0;
      acc          <= '0;
      cnt          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.quo_rd   <= '0;
      bus.rem_rd   <= '0;
      bus.div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            dvd          <= bus.rs1_reg;
            dvs          <= bus.rs2_reg;
            acc          <= '0;
            cnt          <= CW'(N);
            bus.busy     <= 1'b1;
            bus.div_zero <= 1'b0;
            if (bus.rs2_reg == '0) begin
              // Zero divisor: go straight to DONE with the fixed results
              // already loaded, so they are visible in the done cycle.
              state        <= DONE;
              bus.done     <= 1'b1;
              bus.quo_rd   <= '1;
              bus.rem_rd   <= bus.rs1_reg;
              bus.div_zero <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          acc <= acc_nxt;
          dvd <= dvd_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            // Last iteration: load the results from the next-state values,
            // so they are already in place while done is high.
            state      <= DONE;
            bus.done   <= 1'b1;
            bus.quo_rd <= dvd_nxt;
            bus.rem_rd <= acc_nxt;
          end
        end

        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and randomized checks for div_seq (N = 16).
// Cycle k means the clock period after accept edge k-1. The accept edge is
// edge 0. Outputs are sampled on the falling edge. Inputs are driven 1 ns
// after the rising edge, or on the falling edge just before the edge that
// samples them.
module tb_div_seq;
  localparam int N = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  div_seq_if #(.N(N)) bus ();

  div_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Full-window directed op. It watches N+4 cycles after accept, so it can
  // count done pulses and busy cycles. If pulse is set, it also raises a
  // 50/5 start in cycles 4 and N+1; the divider must ignore both.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] eq, input logic [N-1:0] er,
                        input logic edz, input bit pulse);
    int done_at = 0;
    int n_done = 0;
    int n_busy = 0;
    int exp_at;
    logic [N-1:0] q_s = '0;
    logic [N-1:0] r_s = '0;
    logic dz_s = 1'b0;
    exp_at = (b == '0) ? 1 : N + 1;
    exp_q.push_back(eq);
    exp_q.push_back(er);
    @(negedge clk);
    bus.start = 1'b1; bus.rs1_reg = a; bus.rs2_reg = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= N + 4; k++) begin
      @(negedge clk);
      if (k == 1) check("dz_at_accept", 32'(bus.div_zero), 32'(b == '0));
      if (bus.done) begin
        n_done++;
        if (done_at == 0) begin
          done_at = k;
          q_s = bus.quo_rd; r_s = bus.rem_rd; dz_s = bus.div_zero;
        end
      end
      if (bus.busy) n_busy++;
      if (pulse && (k == 4 || k == N + 1)) begin
        bus.start = 1'b1; bus.rs1_reg = 16'd50; bus.rs2_reg = 16'd5;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    check("done_cycle", 32'(done_at), 32'(exp_at));
    check("done_count", 32'(n_done), 32'd1);
    check("busy_cycles", 32'(n_busy), 32'(exp_at));
    check("quo", 32'(q_s), 32'(exp_q.pop_front()));
    check("rem", 32'(r_s), 32'(exp_q.pop_front()));
    check("div_zero", 32'(dz_s), 32'(edz));
    check("hold_quo", 32'(bus.quo_rd), 32'(eq));
    check("hold_rem", 32'(bus.rem_rd), 32'(er));
  endtask

  // Compact op for random runs. It returns at the done cycle, so the next
  // call's accept lands on the first IDLE cycle after DONE (back-to-back).
  task automatic run_rand(input logic [N-1:0] a, input logic [N-1:0] b);
    int lat = 0;
    int unsigned prod;
    logic [N-1:0] eq, er;
    eq = (b == '0) ? '1 : a / b;
    er = (b == '0) ? a  : a % b;
    exp_q.push_back(eq);
    exp_q.push_back(er);
    @(negedge clk);
    bus.start = 1'b1; bus.rs1_reg = a; bus.rs2_reg = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= N + 2; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    check("rnd_latency", 32'(lat), (b == '0) ? 32'd1 : 32'(N + 1));
    check("rnd_quo", 32'(bus.quo_rd), 32'(exp_q.pop_front()));
    check("rnd_rem", 32'(bus.rem_rd), 32'(exp_q.pop_front()));
    check("rnd_dz", 32'(bus.div_zero), 32'(b == '0));
    if (b != '0) begin
      prod = 32'(bus.quo_rd) * 32'(b) + 32'(bus.rem_rd);
      check("rnd_identity", prod, 32'(a));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n_done;
    logic [N-1:0] ra, rb;
    int sel;
    bus.start = 1'b0; bus.rs1_reg = '0; bus.rs2_reg = '0;

    // Reset held over several edges, with start asserted to show it is
    // overridden.
    bus.start = 1'b1; bus.rs1_reg = 16'd9; bus.rs2_reg = 16'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_quo", 32'(bus.quo_rd), 32'd0);
    check("rst_rem", 32'(bus.rem_rd), 32'd0);
    check("rst_dz", 32'(bus.div_zero), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(16'd100,  16'd7,      16'd14,     16'd2,      1'b0, 1'b0);
    run_op(16'hFFFF, 16'd1,      16'hFFFF,   16'd0,      1'b0, 1'b0);
    run_op(16'hFFFF, 16'h8001,   16'd1,      16'h7FFE,   1'b0, 1'b0);
    run_op(16'd5,    16'd0,      16'hFFFF,   16'd5,      1'b1, 1'b0);
    run_op(16'd9,    16'd3,      16'd3,      16'd0,      1'b0, 1'b0);
    run_op(16'd3,    16'd9,      16'd0,      16'd3,      1'b0, 1'b1);
    run_op(16'h8000, 16'hFFFF,   16'd0,      16'h8000,   1'b0, 1'b0);

    // Reset in the middle of RUN: the operation is abandoned with no done.
    n_done = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.rs1_reg = 16'd1000; bus.rs2_reg = 16'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.done) n_done++;
      if (k == 8) rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    @(negedge clk);
    check("midrst_no_done", 32'(n_done + int'(bus.done)), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_quo", 32'(bus.quo_rd), 32'd0);
    check("midrst_rem", 32'(bus.rem_rd), 32'd0);
    check("midrst_dz", 32'(bus.div_zero), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    run_op(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 1'b0);

    // Randomized back-to-back operations.
    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 9));
      ra  = (sel == 9) ? N'($urandom_range(0, 20)) : N'($urandom);
      if (sel == 0)      rb = '0;
      else if (sel < 3)  rb = N'($urandom_range(1, 15));
      else if (sel < 5)  rb = 16'h8000 | N'($urandom);
      else               rb = N'($urandom);
      run_rand(ra, rb);
    end

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
